// File: rtl/nal_pkg.sv
// Shared NAL parser definitions: scanner states and stream limits.
// Also used by the NAL unit extractor.
package nal_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        IN_NAL,
        FLUSH_Z,
        DRAIN
    } scan_state_t;

    localparam logic [7:0] START_CODE_PREFIX = 8'h01;
    localparam int NAL_MAX_BYTES = 384;
    localparam int NAL_LEN_W = 10;

endpackage

// File: rtl/nal_out_reg.sv
// Output holding register for the scanner.
// Carries sop/eop/len with each byte and holds it while stalled.
module nal_out_reg #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [7:0]       ld_byte,
    input  logic             ld_sop,
    input  logic             ld_eop,
    input  logic [LEN_W-1:0] ld_len,
    input  logic             out_ready,
    output logic             slot_free,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic [LEN_W-1:0] out_len
);

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_len   <= '0;
        end else if (ld) begin
            out_valid <= 1'b1;
            out_byte  <= ld_byte;
            out_sop   <= ld_sop;
            out_eop   <= ld_eop;
            out_len   <= ld_len;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nal_start_code_scanner.sv
// Annex-B start-code scanner: strips 3/4-byte start codes and
// trailing zeros, frames each NAL with sop/eop/len.
module nal_start_code_scanner
    import nal_pkg::*;
#(
    parameter int MAX_NAL_BYTES = NAL_MAX_BYTES,
    parameter int LEN_W         = NAL_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [LEN_W-1:0] out_len,
    output logic             err_oversize,
    output logic             err_zero_run
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_NAL_BYTES);

    scan_state_t state, state_d;
    logic [1:0] zrun, zrun_d, fz, fz_d, zinc;
    logic [7:0] h, h_d, d_byte, d_byte_d, cbyte;
    logic hv, hv_d, h_first, h_first_d;
    logic d_last, d_last_d, ovf, ovf_d;
    logic [LEN_W-1:0] cnt, cnt_d;
    logic slot_free, xfer, b_zero, sc, is_data, zmid;
    logic commit, term, ovs_p, zr_p;
    logic ld, ld_sop, ld_eop;
    logic [7:0] ld_byte;
    logic [LEN_W-1:0] ld_len;

    assign in_ready = !reset && slot_free &&
                      (state == SEARCH || state == IN_NAL);
    assign xfer    = in_valid && in_ready;
    assign b_zero  = (in_byte == 8'h00);
    assign sc      = (in_byte == START_CODE_PREFIX) && zrun[1];
    assign is_data = !b_zero && !sc;
    assign zmid    = (zrun == 2'd1) || (zrun == 2'd2);
    assign zinc    = (zrun == 2'd3) ? 2'd3 : zrun + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEARCH;
            zrun         <= '0;
            fz           <= '0;
            h            <= '0;
            hv           <= 1'b0;
            h_first      <= 1'b0;
            d_byte       <= '0;
            d_last       <= 1'b0;
            ovf          <= 1'b0;
            cnt          <= '0;
            err_oversize <= 1'b0;
            err_zero_run <= 1'b0;
        end else begin
            state        <= state_d;
            zrun         <= zrun_d;
            fz           <= fz_d;
            h            <= h_d;
            hv           <= hv_d;
            h_first      <= h_first_d;
            d_byte       <= d_byte_d;
            d_last       <= d_last_d;
            ovf          <= ovf_d;
            cnt          <= cnt_d;
            err_oversize <= ovs_p;
            err_zero_run <= zr_p;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            SEARCH:
                if (xfer && sc && !in_last) state_d = IN_NAL;
            IN_NAL:
                if (xfer) begin
                    unique case (1'b1)
                        b_zero:
                            if (in_last) state_d = SEARCH;
                        sc:
                            if (in_last) state_d = SEARCH;
                        is_data && zmid:
                            state_d = FLUSH_Z;
                        is_data && !zmid:
                            if (in_last) state_d = DRAIN;
                    endcase
                end
            FLUSH_Z:
                if (slot_free && fz == 2'd0)
                    state_d = d_last ? DRAIN : IN_NAL;
            DRAIN:
                if (slot_free) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        zrun_d    = zrun;
        fz_d      = fz;
        h_d       = h;
        hv_d      = hv;
        h_first_d = h_first;
        d_byte_d  = d_byte;
        d_last_d  = d_last;
        ovf_d     = ovf;
        cnt_d     = cnt;
        commit    = 1'b0;
        term      = 1'b0;
        cbyte     = in_byte;
        ovs_p     = 1'b0;
        zr_p      = 1'b0;
        ld        = 1'b0;
        ld_byte   = h;
        ld_sop    = h_first;
        ld_eop    = 1'b0;
        ld_len    = '0;
        unique case (state)
            SEARCH:
                if (xfer) zrun_d = (b_zero && !in_last) ? zinc : 2'd0;
            IN_NAL:
                if (xfer) begin
                    unique case (1'b1)
                        b_zero: begin
                            zrun_d = zinc;
                            term   = in_last;
                        end
                        sc:
                            term = 1'b1;
                        is_data && zmid: begin
                            fz_d     = zrun;
                            d_byte_d = in_byte;
                            d_last_d = in_last;
                            zrun_d   = 2'd0;
                        end
                        is_data && !zmid: begin
                            zr_p   = (zrun == 2'd3);
                            commit = 1'b1;
                            zrun_d = 2'd0;
                        end
                    endcase
                end
            FLUSH_Z:
                if (slot_free) begin
                    commit = 1'b1;
                    if (fz != 2'd0) begin
                        cbyte = 8'h00;
                        fz_d  = fz - 2'd1;
                    end else begin
                        cbyte = d_byte;
                    end
                end
            DRAIN:
                if (slot_free) term = 1'b1;
            default: ;
        endcase

        // Committing pushes the held byte out; its eop is now known to be 0.
        if (commit) begin
            if (cnt == MAX_CNT) begin
                ovs_p = !ovf;
                ovf_d = 1'b1;
            end else begin
                ld        = hv;
                h_d       = cbyte;
                h_first_d = !hv;
                hv_d      = 1'b1;
                cnt_d     = cnt + LEN_W'(1);
            end
        end

        if (term) begin
            ld     = hv;
            ld_eop = 1'b1;
            ld_len = cnt;
            hv_d   = 1'b0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            zrun_d = 2'd0;
        end
    end

    nal_out_reg #(
        .LEN_W(LEN_W)
    ) u_out (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld),
        .ld_byte  (ld_byte),
        .ld_sop   (ld_sop),
        .ld_eop   (ld_eop),
        .ld_len   (ld_len),
        .out_ready(out_ready),
        .slot_free(slot_free),
        .out_byte (out_byte),
        .out_valid(out_valid),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .out_len  (out_len)
    );

endmodule

// File: doc/nal_start_code_scanner.md
# nal_start_code_scanner

Byte-serial Annex-B start-code scanner in the camera decoder's NAL parser. It sits directly upstream of the NAL unit extractor. It accepts the raw elementary byte stream, finds 3- and 4-byte start codes (00 00 01 / 00 00 00 01), and strips them along with trailing zero bytes. It emits each NAL unit as a framed byte stream with start-of-packet, end-of-packet and length markers, which the extractor converts into its start/end/payload signals.

## Interface
- MAX_NAL_BYTES, 384 — maximum bytes kept per NAL unit; equals the extractor buffer capacity (3072 bits).
- LEN_W, 10 — width of the length output.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_last  in  1  in_byte is the final byte of the stream (flush).
- in_ready  out  1  scanner accepts in_byte this cycle.
- out_byte  out  8  NAL byte, with start code removed.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  downstream accepts the output.
- out_sop  out  1  first byte of a NAL (the header byte).
- out_eop  out  1  last kept byte of a NAL.
- out_len  out  LEN_W  NAL byte count; valid only when out_eop=1.
- err_oversize  out  1  one-cycle pulse on the first byte dropped because the NAL exceeded MAX_NAL_BYTES.
- err_zero_run  out  1  one-cycle pulse when more than 2 zeros are followed by a byte other than 0x01.

## Operation
- A transfer occurs when in_valid and in_ready are both 1. Output transfers likewise use out_valid and out_ready.
- zrun: saturating count (0..3) of consecutive 0x00 bytes accepted but not yet committed. Zeros are never emitted until a later non-zero byte proves they are payload.
- H: one-byte hold register with flag hv. Each committed byte waits in H until the next commit or a termination decides its eop.
- States:
  - SEARCH: discard every byte. When 0x01 arrives with zrun≥2, go to IN_NAL with cnt=0 and zrun=0.
  - IN_NAL:
    - 0x00: zrun++ (saturating at 3).
    - 0x01 with zrun≥2: start code. Emit H with eop=1 if hv, discard pending zeros, begin a new NAL.
    - Any other byte with zrun 1..2: go to FLUSH_Z to commit the zeros, then the byte.
    - Any other byte with zrun 3: pulse err_zero_run, drop the zeros, commit the byte.
    - Any other byte with zrun 0: commit the byte.
  - FLUSH_Z: commit one pending zero per output slot, then the deferred byte. Return to IN_NAL.
  - DRAIN: the terminating byte was itself a data byte, so two output slots are needed: H with eop=0, then the new byte with eop=1.
- Commit of byte D: if hv, present H (sop if it is the NAL's first byte, eop=0). Then H←D and cnt++.
  - If cnt is already MAX_NAL_BYTES, D is dropped and err_oversize pulses once per NAL.
  - eop still lands on the last kept byte.
- in_last on an accepted byte: after processing it, terminate the NAL (H emitted with eop=1), discard pending zeros and go to SEARCH.
- Empty NAL (start code directly followed by another start code or by in_last): no output bytes at all.
- out_len equals the count of kept bytes (at most MAX_NAL_BYTES). It is presented with eop.
- Out-of-stream zeros before the first start code and trailing zeros are never emitted.

## Timing
- Reset values: state=SEARCH, zrun=0, hv=0, cnt=0.
- Output reset values: out_valid=0, out_byte=0, out_sop=0, out_eop=0, out_len=0, err_*=0, in_ready=0 during reset.
- in_ready = (state ∈ {SEARCH, IN_NAL}) && (!out_valid || out_ready). This is combinational from out_ready.
- All outputs are registered. A data byte appears on out_* no earlier than 1 cycle after the transfer of its successor decision byte (the next non-zero byte, a start code, or in_last).
- out_* holds stable while out_valid && !out_ready.
- FLUSH_Z costs one output slot per pending zero plus one for the deferred byte. in_ready=0 throughout.
- Reset asserted mid-NAL discards H, zeros and the partial NAL. No eop is emitted.

## Structure
- Shared package nal_pkg:
  - scanner state enum (SEARCH, IN_NAL, FLUSH_Z, DRAIN);
  - START_CODE_PREFIX=8'h01;
  - NAL_MAX_BYTES=384, shared with the extractor;
  - NAL_LEN_W=10.
- Single module. The output register slice is natural as sub-module nal_out_reg (valid/ready holding register with sop/eop/len sideband).

## Test plan
- 00 00 01 65 88 84 00 00 01 41 9A, in_last on 9A:
  - NAL1 = 65(sop) 88 84(eop, len=3);
  - NAL2 = 41(sop) 9A(eop, len=2).
- 00 00 00 01 67 00 00 03 01 00 00 01: 4-byte start code handled. Output 67(sop) 00 00 03 01(eop, len=5); emulation-prevention bytes pass untouched.
- FF 12 00 00 01 09 F0 00 00 00 00 01 … in_last: leading garbage discarded. Output 09(sop) F0(eop, len=2); trailing zeros dropped.
- Start code followed by 400 bytes of 0xAA, then in_last: 384 bytes out, eop on byte 384 with len=384, err_oversize pulses exactly once.
- 00 00 01 00 00 01 40: empty NAL produces no output. Then 40 is output with sop=eop=1, len=1.
- Random out_ready backpressure (50%) on scenario 1: identical byte sequence. No drop or duplicate; out_* stable while stalled.
